// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/response bundle between decoder and the multiply/divide unit
// The master is the issuing pipeline; the slave is muldiv_unit.
interface muldiv_if #(parameter int DATA_W = 32);
  logic              start;
  logic [4:0]        alu_ctl;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  modport master (
    output start, alu_ctl, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, alu_ctl, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, fixed DATA_W-cycle latency
// Magnitudes are iterated in one shared 2*DATA_W work register; signs are restored at the end.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam logic [4:0] OP_MUL   = 5'b00010;
  localparam logic [4:0] OP_MULH  = 5'b00011;
  localparam logic [4:0] OP_MULSU = 5'b00100;
  localparam logic [4:0] OP_MULU  = 5'b00101;
  localparam logic [4:0] OP_DIV   = 5'b00110;
  localparam logic [4:0] OP_DIVU  = 5'b00111;
  localparam logic [4:0] OP_REM   = 5'b01000;
  localparam logic [4:0] OP_REMU  = 5'b01001;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e              state_q;
  logic [4:0]          op_q;
  logic [DATA_W-1:0]   opnd_q;
  logic [2*DATA_W-1:0] work_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_q;
  logic                rem_neg_q;
  logic                divz_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   result_q;

  // Acceptance-side decode of the incoming request
  logic              start_ok;
  logic              in_div;
  logic              signed_a;
  logic              signed_b;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  always_comb begin
    start_ok = bus.start && (bus.alu_ctl >= OP_MUL) && (bus.alu_ctl <= OP_REMU);
    in_div   = (bus.alu_ctl >= OP_DIV);
    signed_a = (bus.alu_ctl == OP_MUL) || (bus.alu_ctl == OP_MULH) ||
               (bus.alu_ctl == OP_MULSU) || (bus.alu_ctl == OP_DIV) ||
               (bus.alu_ctl == OP_REM);
    signed_b = (bus.alu_ctl == OP_MUL) || (bus.alu_ctl == OP_MULH) ||
               (bus.alu_ctl == OP_DIV) || (bus.alu_ctl == OP_REM);
    a_neg    = signed_a && bus.op_a[DATA_W-1];
    b_neg    = signed_b && bus.op_b[DATA_W-1];
    a_mag    = a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
    b_mag    = b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
  end

  // One iteration step. Multiply: low half holds the multiplier and shifts out LSB first.
  // Divide: low half holds the dividend shifting out MSB first, quotient bits shift in.
  logic                is_div_q;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic                div_ge;
  logic [DATA_W-1:0]   div_rem_d;
  logic [2*DATA_W-1:0] step_d;

  always_comb begin
    is_div_q  = (op_q >= OP_DIV);
    mul_sum   = {1'b0, work_q[2*DATA_W-1:DATA_W]} +
                (work_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
    div_shift = {work_q[2*DATA_W-1:DATA_W], work_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_rem_d = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
    if (is_div_q) begin
      step_d = {div_rem_d, work_q[DATA_W-2:0], div_ge};
    end else begin
      step_d = {mul_sum, work_q[DATA_W-1:1]};
    end
  end

  // Sign restoration and special cases applied to the value produced by the last step
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_mag;
  logic [DATA_W-1:0]   rem_mag;
  logic [DATA_W-1:0]   final_d;

  always_comb begin
    prod_fix = neg_q ? (~step_d + 1'b1) : step_d;
    quo_mag  = step_d[DATA_W-1:0];
    rem_mag  = step_d[2*DATA_W-1:DATA_W];
    final_d  = '0;
    case (op_q)
      OP_MUL:   final_d = prod_fix[DATA_W-1:0];
      OP_MULH,
      OP_MULSU,
      OP_MULU:  final_d = prod_fix[2*DATA_W-1:DATA_W];
      OP_DIV:   final_d = divz_q ? '1 : (neg_q ? (~quo_mag + 1'b1) : quo_mag);
      OP_DIVU:  final_d = divz_q ? '1 : quo_mag;
      // With a zero divisor the remainder magnitude is |op_a|, so the sign fix returns op_a
      OP_REM:   final_d = rem_neg_q ? (~rem_mag + 1'b1) : rem_mag;
      OP_REMU:  final_d = rem_mag;
      default:  final_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      opnd_q    <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      divz_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_ok) begin
            op_q      <= bus.alu_ctl;
            opnd_q    <= in_div ? b_mag : a_mag;
            work_q    <= {{DATA_W{1'b0}}, (in_div ? a_mag : b_mag)};
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            divz_q    <= (bus.op_b == '0);
            cnt_q     <= CNT_W'(DATA_W);
            busy_q    <= 1'b1;
            state_q   <= S_CALC;
          end
        end
        S_CALC: begin
          work_q <= step_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            result_q <= final_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit against an arithmetic reference model
// Stimulus pushes expected result and done cycle; a negedge monitor pops on every done.
module tb_muldiv_unit;

  localparam logic [4:0] OP_MUL   = 5'b00010;
  localparam logic [4:0] OP_MULH  = 5'b00011;
  localparam logic [4:0] OP_MULSU = 5'b00100;
  localparam logic [4:0] OP_MULU  = 5'b00101;
  localparam logic [4:0] OP_DIV   = 5'b00110;
  localparam logic [4:0] OP_DIVU  = 5'b00111;
  localparam logic [4:0] OP_REM   = 5'b01000;
  localparam logic [4:0] OP_REMU  = 5'b01001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t expq[$];

  muldiv_if #(.DATA_W(32)) bus ();
  muldiv_unit #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    p  = '0;
    case (op)
      OP_MUL:   begin p = sa * sb; return p[31:0]; end
      OP_MULH:  begin p = sa * sb; return p[63:32]; end
      OP_MULSU: begin p = sa * ub; return p[63:32]; end
      OP_MULU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; p = q; return p[31:0];
      end
      OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; p = q; return p[31:0];
      end
      OP_REMU:  return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      exp_t e;
      if (expq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        e = expq.pop_front();
        check("result", bus.result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive a request sampled at the next rising edge k; returns k
  task automatic start_op(logic [4:0] op, logic [31:0] a, logic [31:0] b, output int k);
    bit valid;
    exp_t e;
    valid = (op >= OP_MUL) && (op <= OP_REMU);
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctl = op; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #1;
    k = cyc;
    bus.start = 1'b0;
    bus.op_a = $urandom; bus.op_b = $urandom; bus.alu_ctl = 5'(($urandom_range(0, 31)));
    if (valid) begin
      e.res = ref_model(op, a, b);
      e.cyc = k + 32;
      expq.push_back(e);
      last_res = e.res;
      check("busy_at_accept", 32'(bus.busy), 32'd1);
    end else begin
      check("busy_invalid_op", 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic wait_cycle(int t);
    int n = 0;
    @(negedge clk);
    while (cyc < t && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cyc != t) begin
      tests++; fails++;
      $display("FAIL wait_cycle: reached %0d expected %0d", cyc, t);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0) begin
      tests++; fails++;
      $display("FAIL timeout_idle: busy=%b expected 0 within 100 cycles", bus.busy);
    end
  endtask

  task automatic run_op(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    int k;
    start_op(op, a, b, k);
    wait_idle();
  endtask

  initial begin
    int k;
    logic [4:0] rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.alu_ctl = '0; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);

    // Latency check on the first multiply
    start_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, k);
    wait_cycle(k + 33);
    check("busy_after_done", 32'(bus.busy), 32'd0);
    check("done_after_done", 32'(bus.done), 32'd0);

    run_op(OP_MULH,  32'h8000_0000, 32'h8000_0000);
    run_op(OP_MULSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_MULU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    run_op(OP_REM,   32'hFFFF_FFF9, 32'd2);
    run_op(OP_DIVU,  32'd100, 32'd7);
    run_op(OP_REMU,  32'd100, 32'd7);
    run_op(OP_DIVU,  32'd5, 32'd0);
    run_op(OP_REMU,  32'd5, 32'd0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_REM,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0);
    run_op(OP_REM,   32'hFFFF_FFF9, 32'd0);

    // Starts while busy must be ignored, including the one sampled as done rises
    start_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, k);
    wait_cycle(k + 4);
    bus.start = 1'b1; bus.alu_ctl = OP_MULU; bus.op_a = 32'h1234_5678; bus.op_b = 32'h9ABC_DEF0;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_cycle(k + 31);
    bus.start = 1'b1; bus.alu_ctl = OP_DIVU; bus.op_a = 32'd99; bus.op_b = 32'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_cycle(k + 33);
    check("busy_ignored_starts", 32'(bus.busy), 32'd0);
    run_op(OP_MULU, 32'h0001_0000, 32'h0001_0000);

    // Unsupported code: no busy, result untouched
    start_op(5'b00000, 32'd11, 32'd22, k);
    @(negedge clk);
    check("invalid_busy", 32'(bus.busy), 32'd0);
    check("invalid_result", bus.result, last_res);

    // Reset mid-divide aborts without a done pulse
    start_op(OP_DIV, 32'd1000, 32'd7, k);
    wait_cycle(k + 9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", bus.result, 32'd0);
    repeat (40) @(negedge clk);
    run_op(OP_MUL, 32'd3, 32'd4);

    for (int i = 0; i < 40; i++) begin
      rop = 5'(OP_MUL + $urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(rop, ra, rb);
    end

    repeat (3) @(negedge clk);
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL pending_results: got %0d outstanding expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
